pipe_skid_reg: RTL and testbench

// - Parametrised pipeline register with val/rdy handshake on both sides; successor to plain enable-style stage registers.
// - SKID=1: 2-entry skid buffer; in_rdy depends only on registered state, cutting the combinational ready path between stages.
// - SKID=0: 1-entry stage, ready passes through combinationally; cheaper where timing allows.
// - Sits between TinyRV1 pipeline stages (F/D, D/X, X/W) and on memory request/response paths; flush squashes on redirect.
//

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_entry.sv | 25 ++
 rtl/pipe_skid_reg.sv | 126 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the val/rdy pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY,
    PIPE_HALF,
    PIPE_FULL
  } pipe_state_t;

endpackage

// File: rtl/pipe_entry.sv
// Single payload register with synchronous reset value and load enable.
module pipe_entry #(
  parameter int unsigned      NBITS   = 32,
  parameter logic [NBITS-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [NBITS-1:0] i_d,
  output logic [NBITS-1:0] o_q
);

  logic [NBITS-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with val/rdy handshake on both sides; SKID=1 builds a
// two-entry skid buffer whose in_rdy depends only on registered state.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      NBITS   = 32,
  parameter int unsigned      SKID    = 1,
  parameter logic [NBITS-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_data
);

  pipe_state_t      r_state;
  pipe_state_t      w_state_nxt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_sel_skid;
  logic [NBITS-1:0] w_main_d;
  logic [NBITS-1:0] w_main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PIPE_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_main_en       = 1'b0;
    w_skid_en       = 1'b0;
    w_main_sel_skid = 1'b0;

    out_val = (r_state != PIPE_EMPTY) & ~flush;
    // Without a skid entry, ready must see downstream ready to stay full-rate.
    if (SKID != 0) begin
      in_rdy = (r_state != PIPE_FULL) & ~flush;
    end else begin
      in_rdy = ((r_state == PIPE_EMPTY) | out_rdy) & ~flush;
    end
    w_in_fire  = in_val & in_rdy;
    w_out_fire = out_val & out_rdy;

    case (r_state)
      PIPE_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = PIPE_HALF;
          w_main_en   = 1'b1;
        end
      end
      PIPE_HALF: begin
        if (w_in_fire && w_out_fire) begin
          w_main_en = 1'b1;
        end else if (w_in_fire) begin
          if (SKID != 0) begin
            w_state_nxt = PIPE_FULL;
            w_skid_en   = 1'b1;
          end
        end else if (w_out_fire) begin
          w_state_nxt = PIPE_EMPTY;
        end
      end
      PIPE_FULL: begin
        if (w_out_fire) begin
          w_state_nxt     = PIPE_HALF;
          w_main_en       = 1'b1;
          w_main_sel_skid = 1'b1;
        end
      end
      default: w_state_nxt = PIPE_EMPTY;
    endcase

    // Flush forces both fires low, so only the state needs squashing.
    if (flush) begin
      w_state_nxt = PIPE_EMPTY;
    end
  end

  pipe_entry #(
    .NBITS   (NBITS),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_main_en),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic [NBITS-1:0] w_skid_q;

      pipe_entry #(
        .NBITS   (NBITS),
        .RST_VAL (RST_VAL)
      ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_skid_en),
        .i_d  (in_data),
        .o_q  (w_skid_q)
      );

      assign w_main_d = w_main_sel_skid ? w_skid_q : in_data;
    end else begin : g_noskid
      logic w_unused_skid;
      assign w_unused_skid = w_skid_en ^ w_main_sel_skid;
      assign w_main_d      = in_data;
    end
  endgenerate

  assign out_data = w_main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: one instance per SKID setting, scoreboard per instance.
module tb_pipe_skid_reg;

  localparam int unsigned      NBITS = 32;
  localparam logic [NBITS-1:0] RVAL  = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush    [2];
  logic             in_val   [2];
  logic             in_rdy   [2];
  logic [NBITS-1:0] in_data  [2];
  logic             out_val  [2];
  logic             out_rdy  [2];
  logic [NBITS-1:0] out_data [2];

  int tot = 0;
  int bad = 0;
  int pushes [2];
  int pops   [2];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [NBITS-1:0] q[$];
    logic             exp_rdy;
    logic             exp_val;

    pipe_skid_reg #(
      .NBITS   (NBITS),
      .SKID    (g),
      .RST_VAL (RVAL)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush[g]),
      .in_val   (in_val[g]),
      .in_rdy   (in_rdy[g]),
      .in_data  (in_data[g]),
      .out_val  (out_val[g]),
      .out_rdy  (out_rdy[g]),
      .out_data (out_data[g])
    );

    // Scoreboard: model occupancy from the queue, pop on out_fire, push on in_fire.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        exp_val = (q.size() != 0) && !flush[g];
        if (g == 1) exp_rdy = (q.size() < 2) && !flush[g];
        else        exp_rdy = ((q.size() == 0) || out_rdy[g]) && !flush[g];
        chk($sformatf("in_rdy[s%0d]", g), 32'(in_rdy[g]), 32'(exp_rdy));
        chk($sformatf("out_val[s%0d]", g), 32'(out_val[g]), 32'(exp_val));
        if (out_val[g] && q.size() != 0)
          chk($sformatf("out_data[s%0d]", g), out_data[g], q[0]);
        if (flush[g]) begin
          q.delete();
        end else begin
          if (out_val[g] && out_rdy[g] && q.size() != 0) begin
            void'(q.pop_front());
            pops[g]++;
          end
          if (in_val[g] && in_rdy[g]) begin
            q.push_back(in_data[g]);
            pushes[g]++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    in_val[i]  = 1'b1;
    in_data[i] = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_rdy[i];
      step();
    end
    in_val[i] = 1'b0;
    chk($sformatf("push_acc[s%0d]", i), 32'(ok), 32'd1);
  endtask

  task automatic directed(input int i);
    int p0;
    int q0;
    // reset value
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_val", 32'(out_val[i]), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy[i]), 32'd1);
    chk("rst_out_data", out_data[i], RVAL);
    step();

    // streaming 1..10 at full rate
    out_rdy[i] = 1'b1;
    p0 = pushes[i];
    q0 = pops[i];
    for (int k = 1; k <= 10; k++) begin
      in_val[i]  = 1'b1;
      in_data[i] = 32'(k);
      step();
    end
    in_val[i] = 1'b0;
    chk("stream_acc", 32'(pushes[i] - p0), 32'd10);
    step();
    step();
    chk("stream_out", 32'(pops[i] - q0), 32'd10);

    // backpressure
    p0 = pushes[i];
    q0 = pops[i];
    out_rdy[i] = 1'b0;
    if (i == 1) begin
      push(i, 32'hA);
      push(i, 32'hB);
      in_val[i]  = 1'b1;
      in_data[i] = 32'hC;
      @(negedge clk);
      chk("bp_full_rdy", 32'(in_rdy[i]), 32'd0);
      step();
      step();
      step();
      chk("bp_held", 32'(pushes[i] - p0), 32'd2);
      out_rdy[i] = 1'b1;
      push(i, 32'hC);
      for (int k = 0; k < 4; k++) step();
      chk("bp_drain", 32'(pops[i] - q0), 32'd3);
    end else begin
      push(i, 32'hA);
      in_val[i]  = 1'b1;
      in_data[i] = 32'hB;
      @(negedge clk);
      chk("bp_full_rdy", 32'(in_rdy[i]), 32'd0);
      step();
      step();
      chk("bp_held", 32'(pushes[i] - p0), 32'd1);
      out_rdy[i] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        in_data[i] = 32'hB + 32'(k);
        step();
      end
      in_val[i] = 1'b0;
      chk("bp_rate", 32'(pushes[i] - p0), 32'd6);
      for (int k = 0; k < 3; k++) step();
      chk("bp_drain", 32'(pops[i] - q0), 32'd6);
    end

    // flush while holding data, with a competing input
    out_rdy[i] = 1'b0;
    push(i, 32'h11);
    if (i == 1) push(i, 32'h22);
    p0 = pushes[i];
    flush[i]   = 1'b1;
    in_val[i]  = 1'b1;
    in_data[i] = 32'h33;
    @(negedge clk);
    chk("fl_in_rdy", 32'(in_rdy[i]), 32'd0);
    chk("fl_out_val", 32'(out_val[i]), 32'd0);
    step();
    flush[i]  = 1'b0;
    in_val[i] = 1'b0;
    @(negedge clk);
    chk("fl_after_val", 32'(out_val[i]), 32'd0);
    chk("fl_after_rdy", 32'(in_rdy[i]), 32'd1);
    chk("fl_no_capture", 32'(pushes[i] - p0), 32'd0);
    out_rdy[i] = 1'b1;
    step();
  endtask

  task automatic random_run(input int i);
    for (int n = 0; n < 5000; n++) begin
      rst        = (n == 2500) || ($urandom_range(0, 999) == 0);
      flush[i]   = ($urandom_range(0, 49) == 0);
      in_val[i]  = ($urandom_range(0, 3) != 0);
      out_rdy[i] = (n < 2500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      in_data[i] = $urandom;
      step();
    end
    rst        = 1'b0;
    flush[i]   = 1'b0;
    in_val[i]  = 1'b0;
    out_rdy[i] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    chk($sformatf("rnd_drained[s%0d]", i), 32'(out_val[i]), 32'd0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      flush[i]   = 1'b0;
      in_val[i]  = 1'b0;
      in_data[i] = '0;
      out_rdy[i] = 1'b1;
      pushes[i]  = 0;
      pops[i]    = 0;
    end
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      directed(i);
      random_run(i);
    end
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
